// File: rtl/pwu_rsp_drain_if.sv
// Handshake bundles for the PWU retire register -> drain -> NOU response path.
// Field names match the port names of the drain block.
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 3
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 8
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_WL_RM_WIDTH
`define NOU_WL_RM_WIDTH 2
`endif

interface pwu_retire_if #(
  parameter int SID_W  = `NOU_SID_WIDTH,
  parameter int RSPT_W = `NOU_RSP_TYPE_ID_WIDTH,
  parameter int PKT_W  = `NOU_PKT_ID_WIDTH,
  parameter int ERR_W  = `NOU_ERR_CODE_WIDTH,
  parameter int RM_W   = `NOU_WL_RM_WIDTH
);
  logic              in_vld;
  logic [SID_W-1:0]  in_sid;
  logic [RSPT_W-1:0] in_rsp_type;
  logic [PKT_W-1:0]  in_pkt_id;
  logic              in_status;
  logic [ERR_W-1:0]  in_err_code;
  logic [RM_W-1:0]   in_rm;
  logic              retire_keep;

  // master = retire register, slave = drain
  modport master (output in_vld, in_sid, in_rsp_type, in_pkt_id, in_status, in_err_code, in_rm,
                  input  retire_keep);
  modport slave  (input  in_vld, in_sid, in_rsp_type, in_pkt_id, in_status, in_err_code, in_rm,
                  output retire_keep);
endinterface

interface nou_rsp_if #(
  parameter int SID_W  = `NOU_SID_WIDTH,
  parameter int RSPT_W = `NOU_RSP_TYPE_ID_WIDTH,
  parameter int PKT_W  = `NOU_PKT_ID_WIDTH,
  parameter int ERR_W  = `NOU_ERR_CODE_WIDTH,
  parameter int RM_W   = `NOU_WL_RM_WIDTH
);
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [SID_W-1:0]  rsp_sid;
  logic [RSPT_W-1:0] rsp_type;
  logic [PKT_W-1:0]  rsp_pkt_id;
  logic              rsp_status;
  logic [ERR_W-1:0]  rsp_err_code;
  logic [RM_W-1:0]   rsp_rm;

  modport master (output rsp_vld, rsp_sid, rsp_type, rsp_pkt_id, rsp_status, rsp_err_code, rsp_rm,
                  input  rsp_rdy);
  modport slave  (input  rsp_vld, rsp_sid, rsp_type, rsp_pkt_id, rsp_status, rsp_err_code, rsp_rm,
                  output rsp_rdy);
endinterface

// File: rtl/pwu_rsp_drain.sv
// PWU retire-response drain: FWFT FIFO between the retire register and the NOU
// response bus, with a saturating error counter and sticky first-error capture.
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 3
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 8
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef NOU_WL_RM_WIDTH
`define NOU_WL_RM_WIDTH 2
`endif

module pwu_rsp_drain #(
  parameter int SID_W  = `NOU_SID_WIDTH,
  parameter int RSPT_W = `NOU_RSP_TYPE_ID_WIDTH,
  parameter int PKT_W  = `NOU_PKT_ID_WIDTH,
  parameter int ERR_W  = `NOU_ERR_CODE_WIDTH,
  parameter int RM_W   = `NOU_WL_RM_WIDTH,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  pwu_retire_if.slave      rin,
  nou_rsp_if.master        rsp,
  input  logic             err_clr,
  output logic [15:0]      err_cnt,
  output logic             err_vld,
  output logic [SID_W-1:0] err_sid,
  output logic [PKT_W-1:0] err_pkt_id,
  output logic [ERR_W-1:0] err_code_cap
);
  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pwu_rsp_drain: DEPTH must be a power of 2 and >= 2");
  end

  typedef struct packed {
    logic [SID_W-1:0]  sid;
    logic [RSPT_W-1:0] rsp_type;
    logic [PKT_W-1:0]  pkt_id;
    logic              status;
    logic [ERR_W-1:0]  err_code;
    logic [RM_W-1:0]   rm;
  } beat_t;

  beat_t            mem [DEPTH];
  beat_t            in_beat, head;
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   count;
  logic             push, pop, err_push;
  logic [15:0]      err_cnt_q;

  assign in_beat = '{sid: rin.in_sid, rsp_type: rin.in_rsp_type, pkt_id: rin.in_pkt_id,
                     status: rin.in_status, err_code: rin.in_err_code, rm: rin.in_rm};

  // keep comes from registered count only, so the retire register sees no
  // combinational path back from rsp_rdy
  assign rin.retire_keep = (count == FULL_CNT);
  assign rsp.rsp_vld     = (count != '0);
  assign push            = rin.in_vld & ~rin.retire_keep;
  assign pop             = rsp.rsp_vld & rsp.rsp_rdy;
  assign err_push        = push & rin.in_status;

  assign head             = mem[rptr];
  assign rsp.rsp_sid      = head.sid;
  assign rsp.rsp_type     = head.rsp_type;
  assign rsp.rsp_pkt_id   = head.pkt_id;
  assign rsp.rsp_status   = head.status;
  assign rsp.rsp_err_code = head.err_code;
  assign rsp.rsp_rm       = head.rm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= in_beat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A new error in the same cycle as err_clr wins: it restarts the count at 1
  // and becomes the new first-error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q    <= '0;
      err_vld      <= 1'b0;
      err_sid      <= '0;
      err_pkt_id   <= '0;
      err_code_cap <= '0;
    end else if (err_push) begin
      if (err_clr)                 err_cnt_q <= 16'd1;
      else if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      if (err_clr | ~err_vld) begin
        err_vld      <= 1'b1;
        err_sid      <= rin.in_sid;
        err_pkt_id   <= rin.in_pkt_id;
        err_code_cap <= rin.in_err_code;
      end
    end else if (err_clr) begin
      err_cnt_q    <= '0;
      err_vld      <= 1'b0;
      err_sid      <= '0;
      err_pkt_id   <= '0;
      err_code_cap <= '0;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule
